ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage of the single-cycle KGP-RISC datapath. Holds the program counter and issues word fetches to instruction memory over a req/ack handshake. It presents the fetched instruction to the datapath, then accepts the next PC from the 32-bit 2:1 next-PC mux, which chooses between PC+4 and the branch target. It sits directly upstream of the next-PC mux: it feeds the mux its `pc_plus4` input and consumes the mux output as `npc`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `HALT_INSTR`, default 32'hFFFF_FFFF: instruction encoding that stops fetch.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `npc` in 32: next PC from the next-PC mux.
- `npc_valid` in 1: datapath has finished the current instruction; `npc` is valid this cycle.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; equals `pc`.
- `imem_ack` in 1: memory returns data this cycle.
- `imem_rdata` in 32: fetched word, valid with `imem_ack`.
- `instr` out 32: current instruction.
- `instr_valid` out 1: `instr` and `pc` are valid for execution.
- `pc` out 32: address of the current or pending instruction.
- `pc_plus4` out 32: `pc + 4`; feeds the next-PC mux.
- `halted` out 1: fetch stopped (halt instruction or misalign).
- `misalign` out 1: sticky flag; a non-word-aligned `npc` was accepted.

## Operation
- FSM states: FETCH, EXEC, HALT.
- Reset (`rst`=1 at a clock edge):
  - state=FETCH, `pc`=RESET_PC, `instr`=0.
  - `instr_valid`=0, `halted`=0, `misalign`=0.
  - Reset has priority over every other input.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - `imem_ack`=1 with `imem_rdata` != HALT_INSTR: `instr` <= `imem_rdata`, `instr_valid` <= 1, go to EXEC.
  - `imem_ack`=1 with `imem_rdata` == HALT_INSTR: `instr` <= `imem_rdata`, `instr_valid` stays 0, `halted` <= 1, go to HALT.
  - `npc_valid` is ignored in FETCH.
- EXEC:
  - `imem_req`=0; `instr`, `pc` and `instr_valid`=1 are held stable.
  - `npc_valid`=1 with `npc[1:0]`==0: `pc` <= `npc`, `instr_valid` <= 0, go to FETCH.
  - `npc_valid`=1 with `npc[1:0]`!=0: `pc` <= `npc` (kept for debug), `instr_valid` <= 0, `misalign` <= 1, `halted` <= 1, go to HALT.
  - `imem_ack` is ignored in EXEC.
- HALT:
  - All outputs hold; `imem_req`=0.
  - Exit only via `rst`.
- `imem_req` is decoded from state and also gated by `rst`: it is 0 in any cycle where `rst`=1.
- Arithmetic: `pc_plus4` = `pc` + 32'd4, modulo 2^32. For example, `pc`=FFFF_FFFC gives `pc_plus4`=0000_0000 with no flag.
- No other outputs are registered beyond those listed; `imem_addr` and `pc_plus4` are combinational from `pc`.

## Timing
- First request: `imem_req` rises in the first cycle with `rst`=0 after reset, with `imem_addr`=RESET_PC.
- Fetch latency: `imem_ack` in cycle N gives `instr_valid`=1 in cycle N+1. Memory may take any number of cycles to ack; `imem_req` and `imem_addr` stay stable until the ack.
- Next-PC acceptance: `npc_valid` in cycle M (in EXEC) gives the new `pc` and `imem_req`=1 in cycle M+1.
- Throughput: minimum two cycles per instruction (zero-wait memory, with `npc_valid` in the first EXEC cycle).
- Handshake rule: memory must drop any outstanding request when `imem_req` falls. An ack is legal only in a cycle where `imem_req`=1.
- Simultaneous `imem_ack` and `npc_valid`: only the input relevant to the current state acts; the other is ignored.
- Reset mid-fetch: the pending fetch is abandoned; the next edge starts a fresh fetch at RESET_PC. An ack arriving in the reset cycle is ignored.
- Reset in EXEC or HALT: returns to FETCH at RESET_PC and clears all flags.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning 32'h0000_1234 -> `imem_req`=1 with addr 0 in the first cycle after reset; `instr_valid`=1 and `instr`=0000_1234 next cycle; `pc_plus4`=4.
- Memory ack delayed 3 cycles -> `imem_addr` held at the same value for all 4 request cycles; `instr_valid` rises exactly 1 cycle after the ack.
- In EXEC, `npc_valid`=1 with `npc`=0000_0040 -> next cycle `pc`=40, `instr_valid`=0, `imem_req`=1, `imem_addr`=40.
- `npc`=0000_0042 accepted -> `misalign`=1, `halted`=1, `imem_req`=0 permanently; `rst` clears all three and refetches at RESET_PC.
- Fetch returns FFFF_FFFF -> `halted`=1, `instr_valid` never asserts; later `imem_ack` and `npc_valid` pulses change nothing.
- `pc`=FFFF_FFFC -> `pc_plus4`=0000_0000. Separately, `rst` asserted during a pending fetch with a simultaneous ack -> ack ignored, and the next fetch is at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage for the single-cycle KGP-RISC datapath.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// presents it to the datapath, then waits for the next PC from the next-PC mux.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        misalign
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;
  logic        halted_reg, halted_next;
  logic        misalign_reg, misalign_next;

  // State and registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      instr_reg    <= 32'd0;
      valid_reg    <= 1'b0;
      halted_reg   <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      valid_reg    <= valid_next;
      halted_reg   <= halted_next;
      misalign_reg <= misalign_next;
    end
  end

  // Next-state logic: each state only listens to the input relevant to it.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    valid_next    = valid_reg;
    halted_next   = halted_reg;
    misalign_next = misalign_reg;
    unique case (state_reg)
      FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          if (imem_rdata == HALT_INSTR) begin
            halted_next = 1'b1;
            state_next  = HALT;
          end else begin
            valid_next = 1'b1;
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        if (npc_valid) begin
          // A misaligned target is still latched so it can be inspected.
          pc_next    = npc;
          valid_next = 1'b0;
          if (npc[1:0] == 2'b00) begin
            state_next = FETCH;
          end else begin
            misalign_next = 1'b1;
            halted_next   = 1'b1;
            state_next    = HALT;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Request is suppressed during reset so an abandoned fetch is never re-acked.
  assign imem_req    = (state_reg == FETCH) && !rst;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + 32'd4;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign halted      = halted_reg;
  assign misalign    = misalign_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a table of per-cycle inputs and the outputs
// expected in that same cycle, followed by hand-written halt/reset sequences.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        npc_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misalign;

  int total;
  int bad;

  ifetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .npc_valid  (npc_valid),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .halted     (halted),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        nv;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
    logic        chk;
    logic        req;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic nv, input logic [31:0] n,
                   input logic a, input logic [31:0] d, input logic c,
                   input logic q, input logic [31:0] p, input logic [31:0] i,
                   input logic vl, input logic h, input logic m);
    vec_t e;
    e.rst = r; e.nv = nv; e.npc = n; e.ack = a; e.rdata = d; e.chk = c;
    e.req = q; e.pc = p; e.instr = i; e.valid = vl; e.halted = h; e.mis = m;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic nv, input logic [31:0] n,
                       input logic a, input logic [31:0] d);
    @(negedge clk);
    rst = r; npc_valid = nv; npc = n; imem_ack = a; imem_rdata = d;
    #1;
  endtask

  // Expected outputs in a cycle given the state and the rst input of that cycle.
  task automatic check_all(input string tag, input logic q, input logic [31:0] p,
                           input logic [31:0] i, input logic vl, input logic h,
                           input logic m);
    check({tag, ".imem_req"},    {31'd0, imem_req},    {31'd0, q});
    check({tag, ".imem_addr"},   imem_addr,            p);
    check({tag, ".pc"},          pc,                   p);
    check({tag, ".pc_plus4"},    pc_plus4,             p + 32'd4);
    check({tag, ".instr"},       instr,                i);
    check({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, vl});
    check({tag, ".halted"},      {31'd0, halted},      {31'd0, h});
    check({tag, ".misalign"},    {31'd0, misalign},    {31'd0, m});
  endtask

  initial begin
    int got_valid;
    total = 0;
    bad   = 0;
    rst = 1'b1; npc_valid = 1'b0; npc = '0; imem_ack = 1'b0; imem_rdata = '0;

    //  rst nv npc           ack rdata          chk req pc            instr          vld hlt mis
    v(1, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0,        32'h0,        0, 0, 0);
    v(1, 0, 32'h0,         0, 32'h0,        1,  0, 32'h0,        32'h0,        0, 0, 0);
    v(0, 0, 32'h0,         1, 32'h1234,     1,  1, 32'h0,        32'h0,        0, 0, 0);
    v(0, 0, 32'h0,         0, 32'h0,        1,  0, 32'h0,        32'h1234,     1, 0, 0);
    v(0, 1, 32'h40,        0, 32'h0,        1,  0, 32'h0,        32'h1234,     1, 0, 0);
    v(0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h40,       32'h1234,     0, 0, 0);
    v(0, 1, 32'h80,        0, 32'h0,        1,  1, 32'h40,       32'h1234,     0, 0, 0);
    v(0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h40,       32'h1234,     0, 0, 0);
    v(0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h40,       32'h1234,     0, 0, 0);
    v(0, 1, 32'h80,        1, 32'hABCD0000, 1,  1, 32'h40,       32'h1234,     0, 0, 0);
    v(0, 0, 32'h0,         1, 32'h5555,     1,  0, 32'h40,       32'hABCD0000, 1, 0, 0);
    v(0, 1, 32'hFFFFFFFC,  0, 32'h0,        1,  0, 32'h40,       32'hABCD0000, 1, 0, 0);
    v(0, 0, 32'h0,         1, 32'h11111111, 1,  1, 32'hFFFFFFFC, 32'hABCD0000, 0, 0, 0);
    v(0, 1, 32'h42,        0, 32'h0,        1,  0, 32'hFFFFFFFC, 32'h11111111, 1, 0, 0);
    v(0, 1, 32'h80,        1, 32'h2222,     1,  0, 32'h42,       32'h11111111, 0, 1, 1);
    v(1, 0, 32'h0,         0, 32'h0,        1,  0, 32'h42,       32'h11111111, 0, 1, 1);
    v(0, 0, 32'h0,         1, 32'hFFFFFFFF, 1,  1, 32'h0,        32'h0,        0, 0, 0);
    v(0, 1, 32'h8,         1, 32'h3333,     1,  0, 32'h0,        32'hFFFFFFFF, 0, 1, 0);
    v(0, 0, 32'h0,         0, 32'h0,        1,  0, 32'h0,        32'hFFFFFFFF, 0, 1, 0);
    v(1, 0, 32'h0,         1, 32'h4444,     1,  0, 32'h0,        32'hFFFFFFFF, 0, 1, 0);
    v(0, 0, 32'h0,         1, 32'h1234,     1,  1, 32'h0,        32'h0,        0, 0, 0);
    v(0, 1, 32'h40,        0, 32'h0,        1,  0, 32'h0,        32'h1234,     1, 0, 0);
    v(1, 0, 32'h0,         1, 32'h7777,     1,  0, 32'h40,       32'h1234,     0, 0, 0);
    v(0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h0,        32'h0,        0, 0, 0);
    v(0, 0, 32'h0,         1, 32'h8,        1,  1, 32'h0,        32'h0,        0, 0, 0);
    v(0, 0, 32'h0,         0, 32'h0,        1,  0, 32'h0,        32'h8,        1, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].nv, vecs[k].npc, vecs[k].ack, vecs[k].rdata);
      $display("row %0d: rst=%b nv=%b ack=%b -> req=%b pc=%h instr=%h valid=%b halted=%b misalign=%b",
               k, rst, npc_valid, imem_ack, imem_req, pc, instr, instr_valid, halted, misalign);
      if (vecs[k].chk)
        check_all($sformatf("row%0d", k), vecs[k].req, vecs[k].pc, vecs[k].instr,
                  vecs[k].valid, vecs[k].halted, vecs[k].mis);
    end

    // Misaligned target from EXEC: halt is permanent while stray pulses arrive.
    drive(0, 1, 32'h3, 0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      drive(0, c[0], 32'h10, ~c[0], 32'h9999);
      $display("halt cycle %0d: req=%b pc=%h halted=%b misalign=%b", c, imem_req, pc, halted, misalign);
      check_all($sformatf("halt%0d", c), 1'b0, 32'h3, 32'h8, 1'b0, 1'b1, 1'b1);
    end

    // Reset clears the halt; memory then acks after three wait cycles.
    drive(1, 0, 32'h0, 0, 32'h0);
    got_valid = 0;
    for (int c = 0; c < 12 && !got_valid; c++) begin
      drive(0, 0, 32'h0, (c == 3), 32'hCAFE0000);
      $display("refetch cycle %0d: req=%b addr=%h ack=%b valid=%b", c, imem_req, imem_addr, imem_ack, instr_valid);
      if (c <= 3) begin
        check($sformatf("wait%0d.imem_req", c), {31'd0, imem_req}, 32'd1);
        check($sformatf("wait%0d.imem_addr", c), imem_addr, 32'h0);
        check($sformatf("wait%0d.instr_valid", c), {31'd0, instr_valid}, 32'd0);
      end else if (c == 4) begin
        check("after_ack.instr_valid", {31'd0, instr_valid}, 32'd1);
        check("after_ack.instr", instr, 32'hCAFE0000);
        check("after_ack.misalign", {31'd0, misalign}, 32'd0);
        got_valid = 1;
      end
    end
    if (!got_valid) begin
      total++;
      bad++;
      $display("FAIL refetch_timeout: got no instr_valid expected instr_valid within bound");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
